// File: rtl/ifm_fetch_ctrl.sv
// ifm_fetch_ctrl
// Upstream feeder for the 3-tap IFM shift buffer. Walks a row-major IFM frame
// in a single-port SRAM (1-cycle read latency). For every output row it streams
// kernel rows 0..2 pixel-by-pixel with aligned sideband tags. A shared stall
// freezes issue and outputs; a read already in flight when the stall lands is
// parked in a 1-entry skid so no pixel is lost or duplicated.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; base address latched on accepted start
// RUN   | issuing one SRAM read per unstalled cycle
// DRAIN | all reads issued; waiting for in-flight / skid data to emit
// DONE  | one-cycle done pulse, then back to IDLE
module ifm_fetch_ctrl #(
    parameter int IFM_W  = 16,
    parameter int IFM_H  = 16,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] ifm_input,
    output logic              ifm_read,
    output logic              win_valid,
    output logic [1:0]        ky_idx,
    output logic              frame_last,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = $clog2(IFM_W);
    localparam int OY_W  = $clog2(IFM_H);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(IFM_W - 1);
    localparam logic [OY_W-1:0]   OY_MAX   = OY_W'(IFM_H - 3);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IFM_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        ky_q, ky_d;
    logic [OY_W-1:0]   oy_q, oy_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // tag travelling alongside the read currently in the SRAM
    logic [1:0] tag_ky_q;
    logic       tag_wv_q;
    logic       tag_last_q;
    logic       rd_pend_q;

    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        skid_ky_q, skid_ky_d;
    logic              skid_wv_q, skid_wv_d;
    logic              skid_last_q, skid_last_d;
    logic              skid_vld_q, skid_vld_d;

    logic [DATA_W-1:0] ifm_input_q, ifm_input_d;
    logic              ifm_read_q, ifm_read_d;
    logic              win_valid_q, win_valid_d;
    logic [1:0]        ky_idx_q, ky_idx_d;
    logic              frame_last_q, frame_last_d;

    logic issue;
    logic col_last;
    logic ky_last;
    logic oy_last;
    logic frame_end;
    logic cur_wv;

    assign issue     = (state_q == S_RUN) && !stall;
    assign col_last  = (col_q == COL_MAX);
    assign ky_last   = (ky_q == 2'd2);
    assign oy_last   = (oy_q == OY_MAX);
    assign frame_end = col_last && ky_last && oy_last;
    assign cur_wv    = (col_q >= COL_W'(2));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; DRAIN waits for the last pixel to be consumed unstalled
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (issue && frame_end) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!rd_pend_q && !skid_vld_q && !stall) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // address walk: row_base tracks base + (oy+ky)*IFM_W without a multiplier
    always_comb begin
        col_d      = col_q;
        ky_d       = ky_q;
        oy_d       = oy_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if ((state_q == S_IDLE) && start) begin
            col_d      = '0;
            ky_d       = '0;
            oy_d       = '0;
            row_base_d = base_addr;
            addr_d     = base_addr;
        end else if (issue && !frame_end) begin
            if (!col_last) begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                col_d = '0;
                if (!ky_last) begin
                    ky_d       = ky_q + 2'd1;
                    row_base_d = row_base_q + ROW_STEP;
                    addr_d     = row_base_q + ROW_STEP;
                end else begin
                    ky_d       = '0;
                    oy_d       = oy_q + OY_W'(1);
                    row_base_d = row_base_q - ROW_STEP;
                    addr_d     = row_base_q - ROW_STEP;
                end
            end
        end
    end

    // counter and address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            ky_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            col_q      <= col_d;
            ky_q       <= ky_d;
            oy_q       <= oy_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    // tag pipeline stage matching the SRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            tag_ky_q   <= '0;
            tag_wv_q   <= 1'b0;
            tag_last_q <= 1'b0;
        end else begin
            rd_pend_q <= issue;
            if (issue) begin
                tag_ky_q   <= ky_q;
                tag_wv_q   <= cur_wv;
                tag_last_q <= frame_end;
            end
        end
    end

    // return path: park in-flight data under stall, otherwise drain skid first
    always_comb begin
        skid_data_d  = skid_data_q;
        skid_ky_d    = skid_ky_q;
        skid_wv_d    = skid_wv_q;
        skid_last_d  = skid_last_q;
        skid_vld_d   = skid_vld_q;
        ifm_input_d  = ifm_input_q;
        ifm_read_d   = ifm_read_q;
        win_valid_d  = win_valid_q;
        ky_idx_d     = ky_idx_q;
        frame_last_d = frame_last_q;
        if (stall) begin
            if (rd_pend_q) begin
                skid_data_d = sram_rdata;
                skid_ky_d   = tag_ky_q;
                skid_wv_d   = tag_wv_q;
                skid_last_d = tag_last_q;
                skid_vld_d  = 1'b1;
            end
        end else if (skid_vld_q) begin
            ifm_input_d  = skid_data_q;
            ifm_read_d   = 1'b1;
            win_valid_d  = skid_wv_q;
            ky_idx_d     = skid_ky_q;
            frame_last_d = skid_last_q;
            skid_vld_d   = 1'b0;
        end else if (rd_pend_q) begin
            ifm_input_d  = sram_rdata;
            ifm_read_d   = 1'b1;
            win_valid_d  = tag_wv_q;
            ky_idx_d     = tag_ky_q;
            frame_last_d = tag_last_q;
        end else begin
            ifm_read_d   = 1'b0;
            win_valid_d  = 1'b0;
            ky_idx_d     = '0;
            frame_last_d = 1'b0;
        end
    end

    // skid and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q  <= '0;
            skid_ky_q    <= '0;
            skid_wv_q    <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_vld_q   <= 1'b0;
            ifm_input_q  <= '0;
            ifm_read_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            ky_idx_q     <= '0;
            frame_last_q <= 1'b0;
        end else begin
            skid_data_q  <= skid_data_d;
            skid_ky_q    <= skid_ky_d;
            skid_wv_q    <= skid_wv_d;
            skid_last_q  <= skid_last_d;
            skid_vld_q   <= skid_vld_d;
            ifm_input_q  <= ifm_input_d;
            ifm_read_q   <= ifm_read_d;
            win_valid_q  <= win_valid_d;
            ky_idx_q     <= ky_idx_d;
            frame_last_q <= frame_last_d;
        end
    end

    assign sram_ren   = issue;
    assign sram_addr  = addr_q;
    assign ifm_input  = ifm_input_q;
    assign ifm_read   = ifm_read_q;
    assign win_valid  = win_valid_q;
    assign ky_idx     = ky_idx_q;
    assign frame_last = frame_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Testbench for ifm_fetch_ctrl: a 4x4 instance for directed latency, stall,
// reset and signed-data cases, and a default 16x16 instance for back-to-back
// frames with random stall. Expected pixel streams come from a nested-loop
// reference over the bench's own SRAM images.
module tb_ifm_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: 4x4
    logic       a_start, a_stall, a_ren, a_read, a_wv, a_last, a_busy, a_done;
    logic [9:0] a_base, a_addr;
    logic [7:0] a_rdata, a_in;
    logic [1:0] a_ky;
    logic [7:0] mem_a [0:1023];

    // instance B: 16x16
    logic       b_start, b_stall, b_ren, b_read, b_wv, b_last, b_busy, b_done;
    logic [9:0] b_base, b_addr;
    logic [7:0] b_rdata, b_in;
    logic [1:0] b_ky;
    logic [7:0] mem_b [0:1023];

    ifm_fetch_ctrl #(.IFM_W(4), .IFM_H(4), .ADDR_W(10), .DATA_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base), .stall(a_stall),
        .sram_ren(a_ren), .sram_addr(a_addr), .sram_rdata(a_rdata),
        .ifm_input(a_in), .ifm_read(a_read), .win_valid(a_wv), .ky_idx(a_ky),
        .frame_last(a_last), .busy(a_busy), .done(a_done)
    );

    ifm_fetch_ctrl #(.IFM_W(16), .IFM_H(16), .ADDR_W(10), .DATA_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base), .stall(b_stall),
        .sram_ren(b_ren), .sram_addr(b_addr), .sram_rdata(b_rdata),
        .ifm_input(b_in), .ifm_read(b_read), .win_valid(b_wv), .ky_idx(b_ky),
        .frame_last(b_last), .busy(b_busy), .done(b_done)
    );

    // single-port SRAMs, 1-cycle read latency
    always @(posedge clk) if (a_ren) a_rdata <= mem_a[a_addr];
    always @(posedge clk) if (b_ren) b_rdata <= mem_b[b_addr];

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] qa[$];
    logic [11:0] qb[$];
    int a_done_cnt = 0, b_done_cnt = 0, a_ren_cnt = 0, b_ren_cnt = 0;
    int a_last_cyc = 0, a_done_cyc = 0;

    // consumer view: a pixel is taken when ifm_read is high and stall is low
    always @(negedge clk) begin
        if (a_ren) a_ren_cnt++;
        if (a_read && !a_stall) begin
            qa.push_back({a_last, a_ky, a_wv, a_in});
            if (a_last) a_last_cyc = cyc;
        end
        if (a_done) begin
            a_done_cnt++;
            a_done_cyc = cyc;
        end
        if (b_ren) b_ren_cnt++;
        if (b_read && !b_stall) qb.push_back({b_last, b_ky, b_wv, b_in});
        if (b_done) b_done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference stream: for each output row, kernel rows 0..2, columns 0..W-1
    task automatic check_seq(input string tag, input int sel, input int w, input int h, input int base);
        logic [11:0] got[$];
        logic [11:0] e;
        logic [7:0]  d;
        int n = 0;
        int bad = -1;
        int addr;
        if (sel == 0) got = qa;
        else          got = qb;
        for (int oy = 0; oy <= h - 3; oy++) begin
            for (int ky = 0; ky < 3; ky++) begin
                for (int col = 0; col < w; col++) begin
                    addr = base + (oy + ky) * w + col;
                    d = (sel == 0) ? mem_a[addr] : mem_b[addr];
                    e = {(oy == h - 3 && ky == 2 && col == w - 1), 2'(ky), (col >= 2), d};
                    if (bad < 0 && (n >= got.size() || got[n] !== e)) bad = n;
                    n++;
                end
            end
        end
        chk({tag, "_count"}, got.size(), n);
        chk({tag, "_first_bad_idx"}, bad, -1);
    endtask

    task automatic wait_done(input string tag, input int sel, input int budget, input bit rnd);
        int d0;
        int i = 0;
        d0 = (sel == 0) ? a_done_cnt : b_done_cnt;
        while (((sel == 0) ? a_done_cnt : b_done_cnt) == d0 && i < budget) begin
            @(posedge clk);
            #1;
            if (rnd) b_stall = ($urandom_range(0, 99) < 30);
            i++;
        end
        b_stall = 1'b0;
        chk({tag, "_done_seen"}, (((sel == 0) ? a_done_cnt : b_done_cnt) != d0), 1);
    endtask

    task automatic start_a();
        @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
    endtask

    task automatic start_b();
        @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
    endtask

    task automatic clear_a();
        qa.delete();
        a_done_cnt = 0;
        a_ren_cnt  = 0;
    endtask

    int wv_cnt, last_cnt, si;

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_stall = 1'b0; a_base = 10'h010;
        b_start = 1'b0; b_stall = 1'b0; b_base = 10'h025;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'(i - 16);
            mem_b[i] = 8'(i * 37 + 5);
        end

        // reset state
        #1;
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_read", a_read, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_input", a_in, 0);
        chk("rst_b_ren", b_ren, 0);
        chk("rst_b_last", b_last, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // basic frame, latency, start ignored while busy
        clear_a();
        start_a();                               // now in cycle 1
        @(negedge clk);
        chk("lat_ren_c1", a_ren, 1);
        chk("lat_addr_c1", a_addr, 10'h010);
        chk("lat_busy_c1", a_busy, 1);
        step();                                  // cycle 2
        @(negedge clk);
        chk("lat_read_c2", a_read, 0);
        step();                                  // cycle 3
        a_start = 1'b1;
        @(negedge clk);
        chk("lat_read_c3", a_read, 1);
        chk("lat_data_c3", a_in, 0);
        step();
        a_start = 1'b0;
        wait_done("basic", 0, 200, 1'b0);
        repeat (4) step();
        check_seq("basic", 0, 4, 4, 16);
        chk("basic_px12", qa[12][7:0], 8'd4);
        chk("basic_px23", qa[23][7:0], 8'd15);
        wv_cnt = 0; last_cnt = 0;
        foreach (qa[i]) begin
            wv_cnt   += int'(qa[i][8]);
            last_cnt += int'(qa[i][11]);
        end
        chk("basic_wv_cnt", wv_cnt, 12);
        chk("basic_last_cnt", last_cnt, 1);
        chk("basic_last_is_24th", qa[23][11], 1);
        chk("basic_ren_cnt", a_ren_cnt, 24);
        chk("basic_done_cnt", a_done_cnt, 1);
        chk("basic_done_lag", a_done_cyc - a_last_cyc, 1);
        chk("basic_idle", a_busy, 0);

        // 3-cycle stall landing while a read is in flight
        clear_a();
        start_a();                               // cycle 1
        repeat (5) step();                       // cycle 6
        a_stall = 1'b1;
        step();                                  // cycle 7
        @(negedge clk);
        chk("stall_read_held", a_read, 1);
        chk("stall_px_held", a_in, 8'd3);
        chk("stall_ren", a_ren, 0);
        chk("stall_addr_held", a_addr, 10'h015);
        step();                                  // cycle 8
        step();                                  // cycle 9
        a_stall = 1'b0;
        step();                                  // cycle 10
        @(negedge clk);
        chk("stall_skid_first", a_in, 8'd4);
        chk("stall_skid_read", a_read, 1);
        wait_done("stall", 0, 200, 1'b0);
        repeat (4) step();
        check_seq("stall", 0, 4, 4, 16);
        chk("stall_ren_cnt", a_ren_cnt, 24);
        chk("stall_done_cnt", a_done_cnt, 1);

        // reset mid-frame, then a clean frame
        clear_a();
        start_a();
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", a_busy, 0);
        chk("mrst_read", a_read, 0);
        chk("mrst_ren", a_ren, 0);
        chk("mrst_addr", a_addr, 0);
        chk("mrst_input", a_in, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("mrst_no_done", a_done_cnt, 0);
        clear_a();
        start_a();
        wait_done("after_rst", 0, 200, 1'b0);
        repeat (3) step();
        check_seq("after_rst", 0, 4, 4, 16);
        chk("after_rst_done_cnt", a_done_cnt, 1);

        // signed data passes through unchanged
        mem_a[16] = 8'h80;
        mem_a[17] = 8'h7F;
        clear_a();
        start_a();
        wait_done("signed", 0, 200, 1'b0);
        repeat (3) step();
        check_seq("signed", 0, 4, 4, 16);
        si = int'($signed(qa[0][7:0]));
        chk("signed_m128", si, -128);
        si = int'($signed(qa[1][7:0]));
        chk("signed_p127", si, 127);

        // 16x16: two back-to-back frames, second one under 30% random stall
        qb.delete(); b_done_cnt = 0; b_ren_cnt = 0;
        start_b();
        wait_done("b_plain", 1, 2000, 1'b0);
        check_seq("b_plain", 1, 16, 16, 'h25);
        chk("b_plain_ren_cnt", b_ren_cnt, 672);
        qb.delete(); b_done_cnt = 0; b_ren_cnt = 0;
        start_b();
        wait_done("b_rand", 1, 4000, 1'b1);
        repeat (5) step();
        check_seq("b_rand", 1, 16, 16, 'h25);
        chk("b_rand_ren_cnt", b_ren_cnt, 672);
        chk("b_rand_done_cnt", b_done_cnt, 1);
        chk("b_rand_idle", b_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifm_fetch_ctrl.md
Name: ifm_fetch_ctrl

Overview:
Upstream feeder for the 3-tap IFM shift buffer. On start, it walks an IFM frame stored row-major in a single-port SRAM with 1-cycle read latency. For each output row it streams kernel rows 0..2 pixel-by-pixel, presenting ifm_input/ifm_read plus aligned sideband tags. It honours the shared stall without losing in-flight SRAM data.

Parameters:
IFM_W, 16, pixels per IFM row (>=3)
IFM_H, 16, IFM rows (>=3); output rows = IFM_H-2
ADDR_W, 10, SRAM address width
DATA_W, 8, pixel width (signed)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin frame; sampled only in IDLE
base_addr  in  ADDR_W  SRAM address of pixel (0,0); latched on accepted start
stall  in  1  global freeze, shared with the shift buffer
sram_ren  out  1  SRAM read enable (combinational: RUN & !stall)
sram_addr  out  ADDR_W  SRAM read address (registered)
sram_rdata  in  DATA_W  SRAM data, valid the cycle after sram_ren
ifm_input  out  DATA_W  pixel to shift buffer (registered)
ifm_read  out  1  shift enable to shift buffer (registered)
win_valid  out  1  with ifm_read: column>=2, so buffer holds a full 3-pixel window after this shift
ky_idx  out  2  with ifm_read: kernel row 0..2 of this pixel
frame_last  out  1  with ifm_read: last pixel of frame
busy  out  1  state != IDLE
done  out  1  1-cycle pulse after final ifm_read cycle

Behaviour:
- Reset: state IDLE. All counters, sram_addr, ifm_input, ifm_read, win_valid, ky_idx, frame_last, done, skid_vld and rd_pend are 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on start.
  - RUN->DRAIN after the last address is issued.
  - DRAIN->DONE once rd_pend=0, skid_vld=0 and the final output has been emitted.
  - DONE->IDLE unconditionally; done=1 only in DONE.
  - start is ignored outside IDLE.
- Counters: col 0..IFM_W-1, ky 0..2, oy 0..IFM_H-3. Address = base + (oy+ky)*IFM_W + col, computed incrementally with no multiplier:
  - row_base += IFM_W on ky increment.
  - row_base -= IFM_W on ky wrap 2->0 with oy increment.
- Issue: in RUN with stall=0, assert sram_ren with current sram_addr, advance counters, and record a tag {ky, col>=2, last} into the tag pipeline. One read is issued per unstalled RUN cycle. In RUN with stall=1: sram_ren=0; counters and address are held.
- rd_pend <= sram_ren every edge.
- Return path, per edge:
  - stall=1 and rd_pend: sram_rdata and its tag are captured into a 1-entry skid; skid_vld<=1. Outputs are held.
  - stall=1 otherwise: outputs held.
  - stall=0 and skid_vld: outputs <= skid; ifm_read<=1; skid_vld<=0.
  - stall=0 and rd_pend: outputs <= sram_rdata and tag; ifm_read<=1.
  - stall=0 otherwise: ifm_read<=0 and sidebands <= 0; ifm_input is held.
- rd_pend and skid_vld are never both 1. No issue occurs under stall, so the skid never overflows.
- Latency: sram_ren in cycle k -> ifm_read=1 in cycle k+2 (no stall). Stall adds exactly its length.
- Totals: 3*(IFM_H-2)*IFM_W reads per frame; same count of ifm_read cycles. Pixel order is ky-major within each oy.
- Throughput: 1 pixel/cycle when unstalled.
- Signed data passes through unmodified.
- Reset mid-frame: immediate return to IDLE. No done pulse; in-flight data is discarded.

Test Plan:
- Basic frame, W=H=4, base=0x10, SRAM[a]=a-0x10, no stall: 24 ifm_read cycles, pixel order 0,1,2,3,4,5,6,7,8,9,10,11,4,5,6,7,8,9,10,11,12,13,14,15. win_valid on cols 2,3; ky_idx sequence 0,1,2 per 4 pixels; frame_last on the 24th; done 1 cycle later.
- Latency: start at cycle 0 -> first sram_ren in cycle 1 (addr 0x10) -> first ifm_read in cycle 3.
- Stall on the cycle after an issue (data in flight), 3 cycles: the returned pixel is held in the skid. Outputs are frozen during stall, then that pixel emits first after release. Sequence has no loss or duplication; total still 24.
- Back-to-back and random stall (30% density) on the default 16x16 frame: 672 reads, data and tags match the reference model, exactly one done.
- start pulsed while busy: ignored, with no change to the sequence. Reset asserted mid-frame: outputs 0 and IDLE at once, no done. A new start afterwards produces a full correct frame.
- Signed data: SRAM holds 0x80 and 0x7F -> ifm_input shows -128 and 127 unchanged.
